// File: rtl/cci_mpf_shim_vtp_svc_arb_if.sv
// VTP service arbiter bundle: N client lookup ports, one translation-service port, status/stats.
// Latency: none (wires only); the slave modport is the arbiter side, master the environment side.
// Backpressure: client requests use En/Rdy; service requests use En/Rdy; responses are never stalled.
interface cci_mpf_shim_vtp_svc_arb_if #(
  parameter int N_CLIENTS       = 2,
  parameter int N_TAGS          = 16,
  parameter int CLIENT_TAG_BITS = 4,
  parameter int VA_IDX_BITS     = 36,
  parameter int PA_IDX_BITS     = 28
);
  localparam int TAG_BITS = $clog2(N_TAGS);
  localparam int C_REQ_W  = VA_IDX_BITS + 1 + CLIENT_TAG_BITS;
  localparam int C_RSP_W  = PA_IDX_BITS + 1 + CLIENT_TAG_BITS + 1;
  localparam int S_REQ_W  = VA_IDX_BITS + 1 + TAG_BITS;
  localparam int S_RSP_W  = PA_IDX_BITS + 1 + TAG_BITS + 1;

  logic [N_CLIENTS-1:0]              c_lookupEn;
  logic [N_CLIENTS-1:0][C_REQ_W-1:0] c_lookupReq;
  logic [N_CLIENTS-1:0]              c_lookupRdy;
  logic [N_CLIENTS-1:0]              c_rspValid;
  logic [C_RSP_W-1:0]                c_rsp;

  logic                              s_lookupEn;
  logic [S_REQ_W-1:0]                s_lookupReq;
  logic                              s_lookupRdy;
  logic                              s_lookupRspValid;
  logic [S_RSP_W-1:0]                s_lookupRsp;

  logic                              errUnexpectedRsp;
  logic [31:0]                       statNumReqs;
  logic [TAG_BITS:0]                 statPeakInflight;

  modport slave (
    input  c_lookupEn, c_lookupReq, s_lookupRdy, s_lookupRspValid, s_lookupRsp,
    output c_lookupRdy, c_rspValid, c_rsp, s_lookupEn, s_lookupReq,
           errUnexpectedRsp, statNumReqs, statPeakInflight
  );

  modport master (
    output c_lookupEn, c_lookupReq, s_lookupRdy, s_lookupRspValid, s_lookupRsp,
    input  c_lookupRdy, c_rspValid, c_rsp, s_lookupEn, s_lookupReq,
           errUnexpectedRsp, statNumReqs, statPeakInflight
  );
endinterface

// File: rtl/cci_mpf_shim_vtp_svc_arb.sv
// Round-robin arbiter multiplexing N VTP clients onto one translation service with server-side tag remapping.
// Latency: request -> s_lookupEn 1 cycle; service response -> c_rspValid strobe 1 cycle.
// Backpressure: client Rdy drops when no tag is free or the output register is held by s_lookupRdy=0; responses never stall.
// Optional statistics are built when CCI_MPF_SHIM_VTP_SVC_ARB_STATS_EN is defined.
module cci_mpf_shim_vtp_svc_arb #(
  parameter int N_CLIENTS       = 2,
  parameter int N_TAGS          = 16,
  parameter int CLIENT_TAG_BITS = 4,
  parameter int VA_IDX_BITS     = 36,
  parameter int PA_IDX_BITS     = 28
) (
  input  logic                        clk,
  input  logic                        reset_n,
  cci_mpf_shim_vtp_svc_arb_if.slave   bus
);
  localparam int TAG_BITS = $clog2(N_TAGS);
  localparam int CID_W    = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int C_REQ_W  = VA_IDX_BITS + 1 + CLIENT_TAG_BITS;
  localparam int C_RSP_W  = PA_IDX_BITS + 1 + CLIENT_TAG_BITS + 1;
  localparam int S_REQ_W  = VA_IDX_BITS + 1 + TAG_BITS;
  localparam int S_RSP_W  = PA_IDX_BITS + 1 + TAG_BITS + 1;

  typedef struct packed {
    logic [CID_W-1:0]           client;
    logic [CLIENT_TAG_BITS-1:0] ctag;
  } tag_entry_t;

  // Per-tag owner; validity is governed entirely by free_tags, so no reset is needed.
  tag_entry_t tag_table [N_TAGS];

  logic [N_TAGS-1:0]    free_tags;
  logic [CID_W-1:0]     rr_ptr;
  logic                 run_en;
  logic                 out_vld;
  logic [S_REQ_W-1:0]   out_req;
  logic [N_CLIENTS-1:0] rsp_strobe;
  logic [C_RSP_W-1:0]   rsp_dat;
  logic                 err_sticky;

  logic                 any_free;
  logic [TAG_BITS-1:0]  alloc_tag;
  logic                 grant_vld;
  logic [CID_W-1:0]     grant_id;
  logic [CID_W-1:0]     rr_next;
  logic                 accept;
  logic [N_CLIENTS-1:0] lookup_rdy;
  logic [C_REQ_W-1:0]   sel_req;

  logic [TAG_BITS-1:0]  rsp_tag;
  logic                 rsp_busy;
  logic                 rsp_stray;

  // Lowest-indexed free tag wins allocation.
  always_comb begin
    any_free  = |free_tags;
    alloc_tag = '0;
    for (int t = N_TAGS - 1; t >= 0; t--) begin
      if (free_tags[t]) alloc_tag = TAG_BITS'(t);
    end
  end

  // Round-robin search starting at rr_ptr, which points one past the last grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (!grant_vld && bus.c_lookupEn[(int'(rr_ptr) + k) % N_CLIENTS]) begin
        grant_vld = 1'b1;
        grant_id  = CID_W'((int'(rr_ptr) + k) % N_CLIENTS);
      end
    end
  end

  // Accept only with a free tag and room in (or draining of) the output register.
  always_comb begin
    rr_next    = (grant_id == CID_W'(N_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
    accept     = run_en && grant_vld && any_free && (!out_vld || bus.s_lookupRdy);
    lookup_rdy = accept ? (N_CLIENTS'(1) << grant_id) : '0;
    sel_req    = bus.c_lookupReq[grant_id];
    rsp_tag    = bus.s_lookupRsp[TAG_BITS:1];
    rsp_busy   = bus.s_lookupRspValid && !free_tags[rsp_tag];
    rsp_stray  = bus.s_lookupRspValid &&  free_tags[rsp_tag];
  end

  // Tag bookkeeping, output request register, response register and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_tags  <= '1;
      rr_ptr     <= '0;
      run_en     <= 1'b0;
      out_vld    <= 1'b0;
      out_req    <= '0;
      rsp_strobe <= '0;
      rsp_dat    <= '0;
      err_sticky <= 1'b0;
    end else begin
      run_en <= 1'b1;
      if (accept) begin
        free_tags[alloc_tag] <= 1'b0;
        rr_ptr               <= rr_next;
        out_vld              <= 1'b1;
        out_req              <= {sel_req[C_REQ_W-1:CLIENT_TAG_BITS], alloc_tag};
      end else if (bus.s_lookupRdy) begin
        out_vld <= 1'b0;
      end
      // Freed tag differs from any allocated one, so both updates can land on the same edge.
      if (rsp_busy) begin
        free_tags[rsp_tag] <= 1'b1;
        rsp_dat <= {bus.s_lookupRsp[S_RSP_W-1:TAG_BITS+1], tag_table[rsp_tag].ctag, bus.s_lookupRsp[0]};
      end
      rsp_strobe <= rsp_busy ? (N_CLIENTS'(1) << tag_table[rsp_tag].client) : '0;
      if (rsp_stray) err_sticky <= 1'b1;
    end
  end

  // Record the owner of each newly allocated tag.
  always_ff @(posedge clk) begin
    if (accept) tag_table[alloc_tag] <= '{client: grant_id, ctag: sel_req[CLIENT_TAG_BITS-1:0]};
  end

  assign bus.c_lookupRdy      = lookup_rdy;
  assign bus.c_rspValid       = rsp_strobe;
  assign bus.c_rsp            = rsp_dat;
  assign bus.s_lookupEn       = out_vld;
  assign bus.s_lookupReq      = out_req;
  assign bus.errUnexpectedRsp = err_sticky;

`ifdef CCI_MPF_SHIM_VTP_SVC_ARB_STATS_EN
  logic [31:0]       num_reqs;
  logic [TAG_BITS:0] inflight;
  logic [TAG_BITS:0] inflight_nxt;
  logic [TAG_BITS:0] peak_inflight;

  // Busy-tag count after this edge's allocation and free.
  always_comb begin
    inflight_nxt = inflight + (TAG_BITS+1)'(accept) - (TAG_BITS+1)'(rsp_busy);
  end

  // Saturating request counter and high-water mark of busy tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_reqs      <= '0;
      inflight      <= '0;
      peak_inflight <= '0;
    end else begin
      if (accept && (num_reqs != 32'hFFFF_FFFF)) num_reqs <= num_reqs + 32'd1;
      inflight <= inflight_nxt;
      if (inflight_nxt > peak_inflight) peak_inflight <= inflight_nxt;
    end
  end

  assign bus.statNumReqs      = num_reqs;
  assign bus.statPeakInflight = peak_inflight;
`else
  assign bus.statNumReqs      = '0;
  assign bus.statPeakInflight = '0;
`endif
endmodule
